ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 set-2 scancode decoder between PS2_Interface and game/VGA logic, replacing the fixed 4-direction converter.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_event_fifo.sv | 60 ++++++
 rtl/ps2_key_tracker.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2 set-2 key tracker.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Bytes that follow the leading E1 of the Pause key sequence.
    localparam int unsigned PAUSE_SKIP = 7;

    localparam int unsigned EVT_W        = 10;
    localparam int unsigned EVT_BRK_BIT  = 9;
    localparam int unsigned EVT_EXT_BIT  = 8;
    localparam int unsigned EVT_CODE_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

    function automatic logic [EVT_W-1:0] pack_evt(input logic brk, input logic ext,
                                                 input logic [7:0] code);
        return {brk, ext, code};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous FIFO with a register-array head; simultaneous push and pop
// succeed even when full, a push into a full FIFO without a pop is dropped.
module ps2_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode decoder: prefix FSM, held-key bitmap for bound keys and
// a make/break event FIFO drained through a valid/ready handshake.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned              NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]    KEY_CODES      = {8'h75, 8'h72, 8'h6B, 8'h74},
    parameter logic [NUM_KEYS-1:0]      KEY_EXT        = {NUM_KEYS{1'b1}},
    parameter int unsigned              FIFO_DEPTH     = 8,
    parameter int unsigned              TIMEOUT_CYCLES = 500000,
    parameter bit                       FILTER_REPEAT  = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic [NUM_KEYS-1:0]           key_held,
    output logic                          evt_valid,
    output logic [EVT_W-1:0]              evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          ovf_clear
);

    localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e          state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                ovf_q, ovf_d;

    logic                emit;
    logic                emit_brk;
    logic                emit_ext;
    logic [NUM_KEYS-1:0] match;
    logic                filtered;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;

    // Prefix FSM; the idle counter only runs while a sequence is partially received.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (byte_valid) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (byte_data == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'(PAUSE_SKIP);
                    end else begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_data != SC_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    emit_ext = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // A bound key matches only with the prefix state its KEY_EXT bit names.
    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_match
        assign match[i] = (byte_data == KEY_CODES[8*i +: 8]) && (emit_ext == KEY_EXT[i]);
    end

    always_comb begin
        held_d = held_q;
        if (emit) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (match[i]) begin
                    held_d[i] = !emit_brk;
                end
            end
        end
    end

    assign filtered = FILTER_REPEAT && !emit_brk && ((match & held_q) != '0);
    assign push     = emit && !filtered;

    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !evt_ready) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (pack_evt(emit_brk, emit_ext, byte_data)),
        .pop_i   (evt_ready),
        .data_o  (evt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (evt_count)
    );

    assign key_held  = held_q;
    assign evt_valid = !fifo_empty;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: expected events go into a queue, a negedge
// monitor pops and compares on every accepted transfer.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int TMO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [3:0]  key_held;
    logic        evt_valid;
    logic [9:0]  evt_data;
    logic        evt_ready;
    logic [3:0]  evt_count;
    logic        overflow;
    logic        ovf_clear;

    logic [9:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .key_held   (key_held),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One-cycle strobe; returns on the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 200;
        while ((exp_q.size() != 0 || evt_valid) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_mis++;
            $display("FAIL drain_timeout got=%0d left want=0", exp_q.size());
        end
    endtask

    // Scoreboard monitor: a transfer is valid & ready seen away from the edge.
    always @(negedge clock) begin
        if (!reset && evt_valid && evt_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_event got=%h want=none", evt_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    n_mis++;
                    $display("FAIL event_data got=%h want=%h", evt_data, e);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        evt_ready  = 1'b1;
        ovf_clear  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_data", 32'(evt_data), 32'h0);
        check("rst_evt_count", 32'(evt_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Extended up arrow make, then break.
        exp_q.push_back(10'b01_0111_0101);
        send_byte(8'hE0); send_byte(8'h75);
        check("up_make_held", 32'(key_held), 32'h8);
        exp_q.push_back(10'b11_0111_0101);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("up_break_held", 32'(key_held), 32'h0);

        // Keypad 8 shares code 75 but is not extended.
        exp_q.push_back(10'b00_0111_0101);
        send_byte(8'h75);
        check("kp8_held", 32'(key_held), 32'h0);

        // Typematic repeat of left arrow queues one event.
        exp_q.push_back(10'b01_0110_1011);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0); send_byte(8'h6B);
        end
        check("left_repeat_held", 32'(key_held), 32'h2);
        exp_q.push_back(10'b11_0110_1011);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("left_break_held", 32'(key_held), 32'h0);
        // Break of a key not held: queued, no bitmap change.
        exp_q.push_back(10'b11_0111_0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        check("stray_break_held", 32'(key_held), 32'h0);

        // Pause key sequence swallowed.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check("pause_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
        exp_q.push_back(10'b00_0001_1100);
        send_byte(8'h1C);
        check("after_pause_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // E0 followed by a byte one cycle before timeout still counts as extended.
        exp_q.push_back(10'b01_0111_0100);
        send_byte(8'hE0);
        repeat (TMO - 2) @(negedge clock);
        send_byte(8'h74);
        check("pre_timeout_held", 32'(key_held), 32'h1);
        exp_q.push_back(10'b11_0111_0100);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check("pre_timeout_release", 32'(key_held), 32'h0);

        // Prefix expires after the idle window.
        send_byte(8'hE0);
        repeat (TMO + 3) @(negedge clock);
        check("timeout_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
        exp_q.push_back(10'b00_0111_0100);
        send_byte(8'h74);
        check("timeout_held", 32'(key_held), 32'h0);
        wait_drain();

        // Fill the FIFO with unbound makes while the consumer stalls.
        @(posedge clock); #1 evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({2'b00, 8'(8'h10 + i)});
            send_byte(8'(8'h10 + i));
        end
        check("full_count", 32'(evt_count), 32'd8);
        check("full_no_ovf", 32'(overflow), 32'h0);
        send_byte(8'h18);
        check("ovf_count", 32'(evt_count), 32'd8);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_head", 32'(evt_data), 32'h010);

        // Push and pop together while full.
        exp_q.push_back(10'h019);
        @(posedge clock); #1;
        evt_ready  = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h19;
        @(posedge clock); #1;
        evt_ready  = 1'b0;
        byte_valid = 1'b0;
        @(negedge clock);
        check("pushpop_count", 32'(evt_count), 32'd8);
        check("pushpop_ovf", 32'(overflow), 32'h1);
        check("pushpop_head", 32'(evt_data), 32'h011);

        // Dropped push beats a simultaneous clear.
        @(posedge clock); #1;
        ovf_clear  = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h1A;
        @(posedge clock); #1;
        ovf_clear  = 1'b0;
        byte_valid = 1'b0;
        @(negedge clock);
        check("drop_beats_clear", 32'(overflow), 32'h1);
        check("drop_count", 32'(evt_count), 32'd8);

        @(posedge clock); #1 ovf_clear = 1'b1;
        @(posedge clock); #1 ovf_clear = 1'b0;
        @(negedge clock);
        check("ovf_cleared", 32'(overflow), 32'h0);

        @(posedge clock); #1 evt_ready = 1'b1;
        wait_drain();
        repeat (2) @(negedge clock);
        check("drained_count", 32'(evt_count), 32'd0);
        check("drained_valid", 32'(evt_valid), 32'h0);

        // Reset in the middle of a prefix discards it.
        send_byte(8'hE0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(10'b00_0111_0101);
        send_byte(8'h75);
        check("mid_reset_held", 32'(key_held), 32'h0);
        wait_drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
